// File: rtl/l2_switch_if.sv
// XGMII signal bundle for both switch ports. The switch drives the TX lanes
// and receives the RX lanes through the master modport.
interface l2_switch_if;
    logic [63:0] xgmii_0_txd;
    logic [7:0]  xgmii_0_txc;
    logic [63:0] xgmii_0_rxd;
    logic [7:0]  xgmii_0_rxc;
    logic [63:0] xgmii_1_txd;
    logic [7:0]  xgmii_1_txc;
    logic [63:0] xgmii_1_rxd;
    logic [7:0]  xgmii_1_rxc;

    modport master (
        output xgmii_0_txd, xgmii_0_txc, xgmii_1_txd, xgmii_1_txc,
        input  xgmii_0_rxd, xgmii_0_rxc, xgmii_1_rxd, xgmii_1_rxc
    );

    modport slave (
        input  xgmii_0_txd, xgmii_0_txc, xgmii_1_txd, xgmii_1_txc,
        output xgmii_0_rxd, xgmii_0_rxc, xgmii_1_rxd, xgmii_1_rxc
    );
endinterface

// File: rtl/l2_switch.sv
// Two-port XGMII block: IPv4/UDP (or ARP) line-rate frame generator on port 0 TX,
// port 0 RX registered straight through to port 1 TX, plus per-second statistics.
module l2_switch (
    input  logic          sys_clk,
    input  logic          sys_rst,
    l2_switch_if.master   xgmii,
    input  logic          tx0_enable,
    input  logic          tx0_ipv6,
    input  logic          tx0_fullroute,
    input  logic          tx0_req_arp,
    input  logic [15:0]   tx0_frame_len,
    input  logic [31:0]   tx0_inter_frame_gap,
    input  logic [31:0]   tx0_ipv4_srcip,
    input  logic [47:0]   tx0_src_mac,
    input  logic [31:0]   tx0_ipv4_gwip,
    input  logic [31:0]   tx0_ipv4_dstip,
    input  logic [127:0]  tx0_ipv6_srcip,
    input  logic [127:0]  tx0_ipv6_dstip,
    output logic [31:0]   tx0_pps,
    output logic [31:0]   tx0_throughput,
    output logic [31:0]   tx0_ipv4_ip
);
    localparam logic [31:0] SEC_CYCLES = 32'd156_250_000;
    localparam logic [63:0] IDLE_D     = 64'h0707070707070707;
    localparam logic [63:0] PRE_D      = 64'hD5555555555555FB;
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_TERM, S_GAP} state_t;
    state_t r_state, w_state_next;

    logic [15:0]      r_len;
    logic [31:0]      r_ifg, r_srcip, r_gwip, r_dstip;
    logic             r_arp;
    logic [47:0]      r_mac;
    logic [12:0]      r_word;
    logic [31:0]      r_gap_left, r_crc;
    logic [63:0]      r_tx0_txd, r_tx1_txd;
    logic [7:0]       r_tx0_txc, r_tx1_txc;
    logic [31:0]      r_sec_cnt, r_frame_acc, r_bit_acc, r_pps, r_tput, r_ip;

    logic             w_enter_pre, w_sec_wrap, w_frame_start, w_unused;
    logic [15:0]      w_fcs_pos, w_tot_len, w_udp_len, w_ip_csum;
    logic [19:0]      w_csum_sum;
    logic [16:0]      w_csum_fold;
    logic [31:0]      w_frame_bits, w_crc_next;
    logic [0:41][7:0] w_hdr;
    logic [7:0]       w_lane_byte [8];
    logic [63:0]      w_txd;
    logic [7:0]       w_txc;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    assign w_unused = ^{tx0_ipv6, tx0_ipv6_srcip, tx0_ipv6_dstip,
                        xgmii.xgmii_1_rxd, xgmii.xgmii_1_rxc};

    // IPv4 header checksum over the constant fields plus length and addresses
    assign w_tot_len   = r_len - 16'd18;
    assign w_udp_len   = r_len - 16'd38;
    assign w_fcs_pos   = r_len - 16'd4;
    assign w_csum_sum  = 20'h04500 + {4'd0, w_tot_len} + 20'h04011
                       + {4'd0, r_srcip[31:16]} + {4'd0, r_srcip[15:0]}
                       + {4'd0, r_dstip[31:16]} + {4'd0, r_dstip[15:0]};
    assign w_csum_fold = {1'b0, w_csum_sum[15:0]} + {13'd0, w_csum_sum[19:16]};
    assign w_ip_csum   = ~(w_csum_fold[15:0] + {15'd0, w_csum_fold[16]});

    always_comb begin
        if (r_arp)
            w_hdr = {48'hFFFF_FFFF_FFFF, r_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                     16'h0001, r_mac, r_srcip, 48'd0, r_gwip};
        else
            w_hdr = {48'hFFFF_FFFF_FFFF, r_mac, 16'h0800, 16'h4500, w_tot_len, 32'd0,
                     16'h4011, w_ip_csum, r_srcip, r_dstip, 16'h0FA0, 16'h0FA1, w_udp_len, 16'd0};
    end

    // Payload lanes feed the CRC first so FCS lanes in the same word see the full sum.
    always_comb begin
        logic [15:0] v_idx, v_k;
        logic [31:0] v_fcs;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        v_idx      = '0;
        v_k        = '0;
        w_crc_next = r_crc;
        for (int l = 0; l < 8; l++) begin
            w_lane_byte[l] = 8'h00;
            v_idx = {r_word, 3'b000} + 16'(l);
            if (v_idx < w_fcs_pos) begin
                if (v_idx < 16'd42) w_lane_byte[l] = w_hdr[v_idx[5:0]];
                w_crc_next = crc_byte(w_crc_next, w_lane_byte[l]);
            end
        end
        v_fcs = ~w_crc_next;
        for (int l = 0; l < 8; l++) begin
            v_idx = {r_word, 3'b000} + 16'(l);
            v_k   = v_idx - w_fcs_pos;
            if (v_idx >= w_fcs_pos) w_lane_byte[l] = v_fcs[{v_k[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!sys_rst) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (tx0_enable) w_state_next = S_PREAMBLE;
            S_PREAMBLE: w_state_next = S_DATA;
            S_DATA:     if (r_word == r_len[15:3] - 13'd1) w_state_next = S_TERM;
            S_TERM:     w_state_next = S_GAP;
            S_GAP:      if (r_gap_left == 32'd0) w_state_next = tx0_enable ? S_PREAMBLE : S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_txd = IDLE_D;
        w_txc = 8'hFF;
        case (r_state)
            S_PREAMBLE: begin
                w_txd = PRE_D;
                w_txc = 8'h01;
            end
            S_DATA: begin
                for (int l = 0; l < 8; l++) w_txd[8*l +: 8] = w_lane_byte[l];
                w_txc = 8'h00;
            end
            S_TERM: begin
                for (int l = 0; l < 8; l++) begin
                    if (3'(l) < r_len[2:0]) begin
                        w_txd[8*l +: 8] = w_lane_byte[l];
                        w_txc[l]        = 1'b0;
                    end else if (3'(l) == r_len[2:0]) begin
                        w_txd[8*l +: 8] = 8'hFD;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_enter_pre = (w_state_next == S_PREAMBLE) && (r_state != S_PREAMBLE);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_len      <= '0;
            r_ifg      <= '0;
            r_arp      <= 1'b0;
            r_mac      <= '0;
            r_srcip    <= '0;
            r_gwip     <= '0;
            r_dstip    <= '0;
            r_word     <= '0;
            r_gap_left <= '0;
            r_crc      <= '1;
        end else begin
            if (w_enter_pre) begin
                r_arp   <= tx0_req_arp;
                r_len   <= tx0_req_arp ? 16'd64 :
                           (tx0_frame_len < 16'd64) ? 16'd64 : tx0_frame_len;
                r_ifg   <= (tx0_inter_frame_gap == 32'd0) ? 32'd1 : tx0_inter_frame_gap;
                r_mac   <= tx0_src_mac;
                r_srcip <= tx0_ipv4_srcip;
                r_gwip  <= tx0_ipv4_gwip;
                // The /24 sweep restarts from the base address whenever the generator leaves IDLE
                r_dstip <= (r_state == S_IDLE || !tx0_fullroute) ? tx0_ipv4_dstip
                                                                 : r_dstip + 32'h100;
            end
            case (r_state)
                S_PREAMBLE: begin
                    r_word <= '0;
                    r_crc  <= '1;
                end
                S_DATA: begin
                    r_word <= r_word + 13'd1;
                    r_crc  <= w_crc_next;
                end
                S_TERM:  r_gap_left <= r_ifg - 32'd1;
                S_GAP:   r_gap_left <= r_gap_left - 32'd1;
                default: ;
            endcase
        end
    end

    assign w_sec_wrap    = (r_sec_cnt == SEC_CYCLES - 32'd1);
    assign w_frame_start = (r_state == S_PREAMBLE);
    assign w_frame_bits  = w_frame_start ? {13'd0, r_len, 3'b000} : 32'd0;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_tx0_txd   <= IDLE_D;
            r_tx0_txc   <= 8'hFF;
            r_tx1_txd   <= IDLE_D;
            r_tx1_txc   <= 8'hFF;
            r_sec_cnt   <= '0;
            r_frame_acc <= '0;
            r_bit_acc   <= '0;
            r_pps       <= '0;
            r_tput      <= '0;
            r_ip        <= '0;
        end else begin
            r_tx0_txd <= w_txd;
            r_tx0_txc <= w_txc;
            r_tx1_txd <= xgmii.xgmii_0_rxd;
            r_tx1_txc <= xgmii.xgmii_0_rxc;
            if (w_frame_start) r_ip <= r_dstip;
            r_sec_cnt <= w_sec_wrap ? 32'd0 : r_sec_cnt + 32'd1;
            // A frame starting on the wrap cycle seeds the new window
            if (w_sec_wrap) begin
                r_pps       <= r_frame_acc;
                r_tput      <= r_bit_acc;
                r_frame_acc <= {31'd0, w_frame_start};
                r_bit_acc   <= w_frame_bits;
            end else begin
                r_frame_acc <= r_frame_acc + {31'd0, w_frame_start};
                r_bit_acc   <= r_bit_acc + w_frame_bits;
            end
        end
    end

    assign xgmii.xgmii_0_txd = r_tx0_txd;
    assign xgmii.xgmii_0_txc = r_tx0_txc;
    assign xgmii.xgmii_1_txd = r_tx1_txd;
    assign xgmii.xgmii_1_txc = r_tx1_txc;
    assign tx0_pps           = r_pps;
    assign tx0_throughput    = r_tput;
    assign tx0_ipv4_ip       = r_ip;
endmodule

// File: tb/tb_l2_switch.sv
// Directed bench for l2_switch: reset state, UDP/ARP frame contents and FCS,
// frame spacing, enable drop, /24 sweep, statistics window and pass-through.
module tb_l2_switch;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] PRE_D  = 64'hD5555555555555FB;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          tx0_enable, tx0_ipv6, tx0_fullroute, tx0_req_arp;
    logic [15:0]   tx0_frame_len;
    logic [31:0]   tx0_inter_frame_gap, tx0_ipv4_srcip, tx0_ipv4_gwip, tx0_ipv4_dstip;
    logic [47:0]   tx0_src_mac;
    logic [127:0]  tx0_ipv6_srcip, tx0_ipv6_dstip;
    logic [31:0]   tx0_pps, tx0_throughput, tx0_ipv4_ip;

    l2_switch_if xif ();

    l2_switch dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .xgmii               (xif),
        .tx0_enable          (tx0_enable),
        .tx0_ipv6            (tx0_ipv6),
        .tx0_fullroute       (tx0_fullroute),
        .tx0_req_arp         (tx0_req_arp),
        .tx0_frame_len       (tx0_frame_len),
        .tx0_inter_frame_gap (tx0_inter_frame_gap),
        .tx0_ipv4_srcip      (tx0_ipv4_srcip),
        .tx0_src_mac         (tx0_src_mac),
        .tx0_ipv4_gwip       (tx0_ipv4_gwip),
        .tx0_ipv4_dstip      (tx0_ipv4_dstip),
        .tx0_ipv6_srcip      (tx0_ipv6_srcip),
        .tx0_ipv6_dstip      (tx0_ipv6_dstip),
        .tx0_pps             (tx0_pps),
        .tx0_throughput      (tx0_throughput),
        .tx0_ipv4_ip         (tx0_ipv4_ip)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          pre_cyc;
    logic [7:0]  frm [$];
    logic [63:0] term_d;
    logic [7:0]  term_c;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get16(input int i);
        return {frm[i], frm[i+1]};
    endfunction

    function automatic logic [31:0] get32(input int i);
        return {frm[i], frm[i+1], frm[i+2], frm[i+3]};
    endfunction

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] frame_fcs(input int n);
        return {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
    endfunction

    task automatic wait_pre();
        bit found;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge sys_clk);
            if (xif.xgmii_0_txd == PRE_D && xif.xgmii_0_txc == 8'h01) found = 1;
        end
        check("preamble_seen", 64'(found), 64'd1);
        pre_cyc = cyc;
    endtask

    // Call at the negedge that shows the preamble; gathers bytes up to the FD lane.
    task automatic collect_frame();
        bit done;
        done = 0;
        frm.delete();
        for (int w = 0; w < 40 && !done; w++) begin
            @(negedge sys_clk);
            for (int l = 0; l < 8 && !done; l++) begin
                if (!xif.xgmii_0_txc[l]) frm.push_back(xif.xgmii_0_txd[8*l +: 8]);
                else begin
                    done   = 1;
                    term_d = xif.xgmii_0_txd;
                    term_c = xif.xgmii_0_txc;
                end
            end
        end
        check("frame_terminated", 64'(done), 64'd1);
    endtask

    task automatic pulse_wrap();
        @(negedge sys_clk);
        force dut.w_sec_wrap = 1'b1;
        @(posedge sys_clk);
        #1 release dut.w_sec_wrap;
        @(negedge sys_clk);
    endtask

    initial begin
        logic [31:0] route_exp [3];
        logic [63:0] d, prev_d;
        logic [7:0]  c;
        int          busy;
        int          first_pre;

        route_exp[0] = 32'hC0A8_0266;
        route_exp[1] = 32'hC0A8_0366;
        route_exp[2] = 32'hC0A8_0466;

        sys_rst             = 1'b0;
        tx0_enable          = 1'b1;
        tx0_ipv6            = 1'b0;
        tx0_fullroute       = 1'b0;
        tx0_req_arp         = 1'b0;
        tx0_frame_len       = 16'd68;
        tx0_inter_frame_gap = 32'd1;
        tx0_ipv4_srcip      = 32'hC0A8_0165;
        tx0_ipv4_dstip      = 32'hC0A8_0266;
        tx0_ipv4_gwip       = 32'hC0A8_0101;
        tx0_src_mac         = 48'h0011_2233_4466;
        tx0_ipv6_srcip      = '0;
        tx0_ipv6_dstip      = '0;
        xif.xgmii_0_rxd     = IDLE_D;
        xif.xgmii_0_rxc     = 8'hFF;
        xif.xgmii_1_rxd     = IDLE_D;
        xif.xgmii_1_rxc     = 8'hFF;

        repeat (3) @(negedge sys_clk);
        check("rst_tx0_txd", xif.xgmii_0_txd, IDLE_D);
        check("rst_tx0_txc", 64'(xif.xgmii_0_txc), 64'hFF);
        check("rst_tx1_txd", xif.xgmii_1_txd, IDLE_D);
        check("rst_tx1_txc", 64'(xif.xgmii_1_txc), 64'hFF);
        check("rst_pps", 64'(tx0_pps), 64'd0);
        check("rst_tput", 64'(tx0_throughput), 64'd0);
        check("rst_ip", 64'(tx0_ipv4_ip), 64'd0);

        // Base frame: preamble on the 2nd edge after reset release
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 check("start_edge1_idle", xif.xgmii_0_txd, IDLE_D);
        @(posedge sys_clk);
        #1 check("start_edge2_pre", xif.xgmii_0_txd, PRE_D);
        check("start_edge2_prec", 64'(xif.xgmii_0_txc), 64'h01);
        first_pre = cyc;
        @(negedge sys_clk);
        collect_frame();
        check("base_len", 64'(frm.size()), 64'd68);
        check("base_word0", {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5], frm[6], frm[7]},
              64'hFFFF_FFFF_FFFF_0011);
        check("base_ethertype", 64'(get16(12)), 64'h0800);
        check("base_ip_totlen", 64'(get16(16)), 64'd50);
        check("base_ip_csum", 64'(get16(24)), 64'hF59F);
        check("base_srcip", 64'(get32(26)), 64'hC0A8_0165);
        check("base_dstip", 64'(get32(30)), 64'hC0A8_0266);
        check("base_udp_len", 64'(get16(38)), 64'd30);
        check("base_term_txc", 64'(term_c), 64'hF0);
        check("base_term_fd", 64'(term_d[39:32]), 64'hFD);
        check("base_fcs", 64'(frame_fcs(68)), 64'(ref_crc(64)));
        check("base_ip_out", 64'(tx0_ipv4_ip), 64'hC0A8_0266);

        // Spacing, then drop enable right after frame 3 starts
        wait_pre();
        check("spacing", 64'(pre_cyc - first_pre), 64'd11);
        collect_frame();
        check("frame2_len", 64'(frm.size()), 64'd68);
        wait_pre();
        tx0_enable = 1'b0;
        collect_frame();
        check("frame3_len", 64'(frm.size()), 64'd68);
        busy = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (xif.xgmii_0_txd != IDLE_D || xif.xgmii_0_txc != 8'hFF) busy++;
        end
        check("idle_after_disable", 64'(busy), 64'd0);

        pulse_wrap();
        check("win1_pps", 64'(tx0_pps), 64'd3);
        check("win1_tput", 64'(tx0_throughput), 64'd1632);

        // /24 sweep across three frames
        tx0_fullroute = 1'b1;
        tx0_enable    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_pre();
            if (i == 2) tx0_enable = 1'b0;
            check("route_ip_out", 64'(tx0_ipv4_ip), 64'(route_exp[i]));
            collect_frame();
            check("route_dstip", 64'(get32(30)), 64'(route_exp[i]));
            check("route_fcs", 64'(frame_fcs(68)), 64'(ref_crc(64)));
        end
        repeat (4) @(negedge sys_clk);
        tx0_fullroute = 1'b0;

        // ARP request
        tx0_req_arp = 1'b1;
        tx0_enable  = 1'b1;
        wait_pre();
        tx0_enable = 1'b0;
        collect_frame();
        check("arp_len", 64'(frm.size()), 64'd64);
        check("arp_ethertype", 64'(get16(12)), 64'h0806);
        check("arp_opcode", 64'(get16(20)), 64'h0001);
        check("arp_sender_ip", 64'(get32(28)), 64'hC0A8_0165);
        check("arp_target_ip", 64'(get32(38)), 64'hC0A8_0101);
        check("arp_term_txc", 64'(term_c), 64'hFF);
        check("arp_term_fd", 64'(term_d[7:0]), 64'hFD);
        check("arp_fcs", 64'(frame_fcs(64)), 64'(ref_crc(60)));
        repeat (4) @(negedge sys_clk);
        tx0_req_arp = 1'b0;

        pulse_wrap();
        check("win2_pps", 64'(tx0_pps), 64'd4);
        check("win2_tput", 64'(tx0_throughput), 64'd2144);

        // Pass-through: one register stage
        prev_d = xif.xgmii_1_txd;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            d = {$urandom, $urandom};
            c = 8'($urandom);
            xif.xgmii_0_rxd = d;
            xif.xgmii_0_rxc = c;
            #1 check("pass_hold", xif.xgmii_1_txd, prev_d);
            @(posedge sys_clk);
            #1;
            check("pass_txd", xif.xgmii_1_txd, d);
            check("pass_txc", 64'(xif.xgmii_1_txc), 64'(c));
            prev_d = d;
        end

        // Asynchronous reset in the middle of a frame
        tx0_enable = 1'b1;
        wait_pre();
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        #1;
        check("midrst_txd", xif.xgmii_0_txd, IDLE_D);
        check("midrst_txc", 64'(xif.xgmii_0_txc), 64'hFF);
        check("midrst_ip", 64'(tx0_ipv4_ip), 64'd0);
        tx0_enable = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
